audio_frame_sequencer: RTL and testbench
========================================

# audio_frame_sequencer

Control block for the PSG half of the audio subsystem. It divides `clk_100` down to the 512 Hz frame rate and walks the 8-step frame sequence, emitting length, sweep and envelope tick pulses to the square1, square2, wave and noise channel datapaths. It owns the four channel length counters and per-channel active flags (the NR52[3:0] readback), and generates the per-channel restart and reset strobes that sequence those datapaths.

## Interface

Parameters:

- `FRAME_DIV`, 195312: `clk_100` cycles per 512 Hz frame step; must be ≥ 2.
- `DIV_W`, 18: divider width; must satisfy `FRAME_DIV` ≤ 2^`DIV_W`.

Ports:

- `clk_100` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `master_en` in 1: NR52[7].
- `trig` in 4: one-cycle pulses, one per channel (bit0 = ch1 … bit3 = ch4). Asserted when the high control byte is written with bit7 = 1.
- `len_load` in 4: one-cycle pulses when a length field is written.
- `len_en` in 4: NR14[6], NR24[6], NR34[6], NR44[6].
- `len1`, `len2`, `len4` in 6: NR11[5:0], NR21[5:0], NR41[5:0].
- `len3` in 8: NR31.
- `dac3_en` in 1: NR30[7].
- `step` out 3: current frame step.
- `len_tick`, `sweep_tick`, `env_tick` out 1: one-cycle pulses.
- `ch_restart` out 4: one-cycle restart pulses to the channel datapaths.
- `ch_active` out 4: NR52[3:0] readback.
- `ch_reset` out 4: hold the channel datapath in reset while high.

## Operation

- Divider `div` counts 0..`FRAME_DIV`-1 while `master_en`=1.
  - At `FRAME_DIV`-1 it wraps to 0 and `step` <= `step`+1 (mod 8, 7→0).
- Tick decode uses the new step value:
  - `len_tick` on steps 0, 2, 4, 6.
  - `sweep_tick` on steps 2, 6.
  - `env_tick` on step 7.
- Length counters:
  - Channels 1, 2 and 4: 7-bit counter, max 64.
  - Channel 3: 9-bit counter, max 256.
  - `len_load[i]`: counter <= max − len field.
  - `trig[i]`: `ch_active[i]` <= 1. Exception: channel 3 with `dac3_en`=0 stays 0. If the counter is 0 it reloads to max.
  - `len_tick` with `len_en[i]`=1 and counter ≠ 0: decrement. Reaching 0 clears `ch_active[i]`.
  - `len_en[i]`=0: counter frozen; active flag unaffected by length.
- `dac3_en`=0 clears `ch_active[3]` on the next edge, regardless of other events.
- Priority within a cycle, per channel: `master_en`=0 > `len_load` > `trig` > tick decrement.
  - `len_load` + `trig` together: load, then the trig rule on the loaded value (no reload, since the loaded value is ≥1).
  - `trig` + tick together: no decrement that cycle.
- `master_en`=0 forces all of the following, and ignores `trig`/`len_load`:
  - `div` = 0, `step` = 0.
  - All ticks 0.
  - All counters 0, all `ch_active` 0.
- `ch_reset[i]` = ~`ch_active[i]`, registered from the next-state value, so it changes in the same cycle as `ch_active`.

## Timing

- Reset values:
  - `div` = 0, `step` = 0.
  - `len_tick`, `sweep_tick`, `env_tick` = 0.
  - `ch_restart` = 0, `ch_active` = 0, `ch_reset` = 4'b1111.
  - Counters = 0.
- Tick pulses and the updated `step` appear on the edge after `div` = `FRAME_DIV`-1. Each tick is high exactly one cycle.
- Period between `len_tick` pulses is 2×`FRAME_DIV`; between `env_tick` pulses, 8×`FRAME_DIV`.
- `trig` sampled at edge N:
  - `ch_active` and `ch_reset` update at N.
  - `ch_restart[i]` is high during cycle N+1 only, and only if the channel became/stayed active.
- A counter hitting 0 on a tick at edge N drops `ch_active` and raises `ch_reset` at edge N.
- Rising `master_en` restarts the divider from 0: the first step increment comes `FRAME_DIV` cycles later, to step 1.
- Reset mid-frame: everything returns to reset values on the next edge; a pending `ch_restart` is cancelled.

## Configuration

- `AUDIO_SEQ_LENGTH_EN`
  - Defined: length counters implemented as above.
  - Undefined: no counters are instantiated, and `len_load`/`len_en`/`len*` are ignored. `ch_active` is set by `trig` and cleared only by `master_en`=0 or `dac3_en`=0 (channel 3). Tick outputs are unchanged.

## Test plan

- `FRAME_DIV`=4, `master_en`=1 for 64 cycles: `step` sequence is 1,2,…,7,0,…; the `len_tick`/`sweep_tick`/`env_tick` counts match the step decode (8/4/2 over 16 steps).
- `len_load[0]` with `len1`=62, `len_en[0]`=1, then `trig[0]`: `ch_active[0]` rises, `ch_restart[0]` pulses the next cycle, and `ch_active[0]` falls on the 2nd `len_tick`.
- `trig[2]` with channel 3 counter 0, `dac3_en`=1, `len_en[2]`=1: counter = 256; `ch_active[2]` falls after 256 `len_tick`s. Repeat with `dac3_en`=0: `ch_active[2]` stays 0 and there is no restart pulse.
- `trig[1]` coincident with `len_tick` and counter = 1: counter stays 1, `ch_active[1]`=1; it expires on the next `len_tick`.
- Clear `master_en` mid-frame with all channels active: the next edge gives `step`=0, `ch_active`=0, `ch_reset`=4'b1111. `trig` while disabled has no effect.
- Assert `reset` the cycle after a `trig`: `ch_restart` never pulses and all outputs return to reset values.

Source files
------------

// File: rtl/audio_frame_sequencer.sv
// audio_frame_sequencer
//   Frame sequencer for the PSG channels. Divides clk_100 down to the 512 Hz
//   frame rate, walks the 8-step frame sequence, and emits length / sweep /
//   envelope tick pulses. It owns the per-channel active flags (NR52[3:0]) and
//   the channel restart and reset strobes.
//
//   Optional feature macro: AUDIO_SEQ_LENGTH_EN
//     defined   - per-channel length counters (ch1/2/4: max 64, ch3: max 256)
//     undefined - no counters; len_load/len_en/len1..len4 are ignored and
//                 ch_active is set by trig, cleared by master_en=0 / dac3_en=0
//
//   Ports
//     clk_100     single clock
//     reset       synchronous, active-high
//     master_en   NR52[7]; low forces divider, step, ticks, counters, flags to 0
//     trig[3:0]   per-channel trigger pulses (bit0 = ch1 .. bit3 = ch4)
//     len_load    per-channel length-field write pulses
//     len_en      per-channel length enable
//     len1/2/4    6-bit length fields, len3 8-bit length field
//     dac3_en     NR30[7]; low keeps channel 3 inactive
//     step        current frame step
//     len_tick / sweep_tick / env_tick   one-cycle frame tick pulses
//     ch_restart  one-cycle restart pulses, one cycle after ch_active rises
//     ch_active   NR52[3:0] readback
//     ch_reset    ~ch_active, holds an idle channel datapath in reset
module audio_frame_sequencer #(
  parameter int FRAME_DIV = 195312,
  parameter int DIV_W     = 18
) (
  input  logic       clk_100,
  input  logic       reset,
  input  logic       master_en,
  input  logic [3:0] trig,
  input  logic [3:0] len_load,
  input  logic [3:0] len_en,
  input  logic [5:0] len1,
  input  logic [5:0] len2,
  input  logic [7:0] len3,
  input  logic [5:0] len4,
  input  logic       dac3_en,
  output logic [2:0] step,
  output logic       len_tick,
  output logic       sweep_tick,
  output logic       env_tick,
  output logic [3:0] ch_restart,
  output logic [3:0] ch_active,
  output logic [3:0] ch_reset
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       step_q, step_d;
  logic             frame_evt;
  logic             len_tick_q, len_tick_d;
  logic             sweep_tick_q, sweep_tick_d;
  logic             env_tick_q, env_tick_d;
  logic [3:0]       restart_pend_q, restart_pend_d;
  logic [3:0]       ch_restart_q, ch_restart_d;
  logic [3:0]       ch_active_q, ch_active_d;
  logic [3:0]       ch_reset_q, ch_reset_d;

`ifdef AUDIO_SEQ_LENGTH_EN
  localparam logic [8:0] LEN_MAX [4] = '{9'd64, 9'd64, 9'd256, 9'd64};
  logic [8:0] len_field [4];
  logic [8:0] len_cnt_q [4];
  logic [8:0] len_cnt_d [4];

  always_comb begin
    len_field[0] = {3'b000, len1};
    len_field[1] = {3'b000, len2};
    len_field[2] = {1'b0, len3};
    len_field[3] = {3'b000, len4};
  end
`else
  logic len_inputs_unused;
  assign len_inputs_unused = ^{len_load, len_en, len1, len2, len3, len4};
`endif

  // Divider, step and tick decode (ticks decode the post-increment step).
  always_comb begin
    div_d  = div_q;
    step_d = step_q;
    frame_evt = master_en && (div_q == DIV_LAST);
    if (!master_en) begin
      div_d  = '0;
      step_d = '0;
    end else if (frame_evt) begin
      div_d  = '0;
      step_d = step_q + 3'd1;
    end else begin
      div_d = div_q + 1'b1;
    end
    len_tick_d   = frame_evt && !step_d[0];
    sweep_tick_d = frame_evt && (step_d[1:0] == 2'b10);
    env_tick_d   = frame_evt && (step_d == 3'd7);
  end

  // Channel state. Priority per channel: master_en=0 > len_load > trig > tick.
  // A trig in the same cycle as a length load applies to the loaded value.
  always_comb begin
    ch_active_d = ch_active_q;
`ifdef AUDIO_SEQ_LENGTH_EN
    for (int unsigned i = 0; i < 4; i++) len_cnt_d[i] = len_cnt_q[i];
`endif
    for (int unsigned i = 0; i < 4; i++) begin
      if (!master_en) begin
        ch_active_d[i] = 1'b0;
`ifdef AUDIO_SEQ_LENGTH_EN
        len_cnt_d[i] = '0;
`endif
      end else begin
`ifdef AUDIO_SEQ_LENGTH_EN
        if (len_load[i]) len_cnt_d[i] = LEN_MAX[i] - len_field[i];
`endif
        if (trig[i]) begin
          ch_active_d[i] = 1'b1;
`ifdef AUDIO_SEQ_LENGTH_EN
          if (len_cnt_d[i] == '0) len_cnt_d[i] = LEN_MAX[i];
        end else if (!len_load[i] && len_tick_d && len_en[i] &&
                     (len_cnt_q[i] != '0)) begin
          len_cnt_d[i] = len_cnt_q[i] - 9'd1;
          if (len_cnt_q[i] == 9'd1) ch_active_d[i] = 1'b0;
`endif
        end
      end
    end
`ifdef AUDIO_SEQ_LENGTH_EN
    // Channels 1, 2 and 4 never exceed 64: keep them 7 bits wide.
    for (int unsigned i = 0; i < 4; i++) begin
      if (i != 2) len_cnt_d[i][8:7] = '0;
    end
`endif
    if (!dac3_en) ch_active_d[2] = 1'b0;
    // Restart is staged one cycle behind the active flag so a reset in the
    // following cycle can still cancel it.
    restart_pend_d = trig & ch_active_d;
    ch_restart_d   = restart_pend_q;
    ch_reset_d     = ~ch_active_d;
  end

  always_ff @(posedge clk_100) begin
    if (reset) begin
      div_q          <= '0;
      step_q         <= '0;
      len_tick_q     <= 1'b0;
      sweep_tick_q   <= 1'b0;
      env_tick_q     <= 1'b0;
      restart_pend_q <= '0;
      ch_restart_q   <= '0;
      ch_active_q    <= '0;
      ch_reset_q     <= '1;
`ifdef AUDIO_SEQ_LENGTH_EN
      for (int unsigned i = 0; i < 4; i++) len_cnt_q[i] <= '0;
`endif
    end else begin
      div_q          <= div_d;
      step_q         <= step_d;
      len_tick_q     <= len_tick_d;
      sweep_tick_q   <= sweep_tick_d;
      env_tick_q     <= env_tick_d;
      restart_pend_q <= restart_pend_d;
      ch_restart_q   <= ch_restart_d;
      ch_active_q    <= ch_active_d;
      ch_reset_q     <= ch_reset_d;
`ifdef AUDIO_SEQ_LENGTH_EN
      for (int unsigned i = 0; i < 4; i++) len_cnt_q[i] <= len_cnt_d[i];
`endif
    end
  end

  assign step       = step_q;
  assign len_tick   = len_tick_q;
  assign sweep_tick = sweep_tick_q;
  assign env_tick   = env_tick_q;
  assign ch_restart = ch_restart_q;
  assign ch_active  = ch_active_q;
  assign ch_reset   = ch_reset_q;

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Bench for audio_frame_sequencer with FRAME_DIV=4. A frame-time model
// (step = enabled cycles / FRAME_DIV mod 8, integer length counters) is checked
// against the DUT every cycle; directed sequences add literal expectations.
module tb_audio_frame_sequencer;

  localparam int FD = 4;
`ifdef AUDIO_SEQ_LENGTH_EN
  localparam bit LEN_ON = 1'b1;
`else
  localparam bit LEN_ON = 1'b0;
`endif
  localparam int LEN_MAX [4] = '{64, 64, 256, 64};

  logic       clk_100 = 1'b0;
  logic       reset, master_en, dac3_en;
  logic [3:0] trig, len_load, len_en;
  logic [5:0] len1, len2, len4;
  logic [7:0] len3;
  logic [2:0] step;
  logic       len_tick, sweep_tick, env_tick;
  logic [3:0] ch_restart, ch_active, ch_reset;

  int checks = 0;
  int errors = 0;

  audio_frame_sequencer #(.FRAME_DIV(FD), .DIV_W(3)) dut (
    .clk_100(clk_100), .reset(reset), .master_en(master_en), .trig(trig),
    .len_load(len_load), .len_en(len_en), .len1(len1), .len2(len2),
    .len3(len3), .len4(len4), .dac3_en(dac3_en), .step(step),
    .len_tick(len_tick), .sweep_tick(sweep_tick), .env_tick(env_tick),
    .ch_restart(ch_restart), .ch_active(ch_active), .ch_reset(ch_reset)
  );

  always #5 clk_100 = ~clk_100;

  // ---------------- behavioural model ----------------
  bit         chk_en = 1'b0;
  int         en_cnt;
  int         m_s;
  logic [2:0] m_step;
  logic       m_lt, m_st, m_et;
  logic [3:0] m_act, m_pend, m_restart;
  int         m_len [4];
  int         field [4];

  always @(posedge clk_100) begin
    if (reset) begin
      en_cnt = 0; m_step = '0; m_lt = 0; m_st = 0; m_et = 0;
      m_act = '0; m_pend = '0; m_restart = '0;
      for (int i = 0; i < 4; i++) m_len[i] = 0;
      chk_en = 1'b1;
    end else begin
      m_restart = m_pend;
      if (!master_en) begin
        en_cnt = 0; m_step = '0; m_lt = 0; m_st = 0; m_et = 0;
        m_act = '0; m_pend = '0;
        for (int i = 0; i < 4; i++) m_len[i] = 0;
      end else begin
        en_cnt++;
        m_s    = (en_cnt / FD) % 8;
        m_step = 3'(m_s);
        m_lt   = (en_cnt % FD == 0) && (m_s % 2 == 0);
        m_st   = (en_cnt % FD == 0) && (m_s % 4 == 2);
        m_et   = (en_cnt % FD == 0) && (m_s == 7);
        field[0] = int'(len1); field[1] = int'(len2);
        field[2] = int'(len3); field[3] = int'(len4);
        for (int i = 0; i < 4; i++) begin
          if (LEN_ON && len_load[i]) m_len[i] = LEN_MAX[i] - field[i];
          if (trig[i]) begin
            m_act[i] = !(i == 2 && !dac3_en);
            if (LEN_ON && m_len[i] == 0) m_len[i] = LEN_MAX[i];
          end else if (LEN_ON && !len_load[i] && m_lt && len_en[i] && m_len[i] > 0) begin
            m_len[i]--;
            if (m_len[i] == 0) m_act[i] = 1'b0;
          end
        end
        if (!dac3_en) m_act[2] = 1'b0;
        m_pend = trig & m_act;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [17:0] exp_v, got_v;
  always @(negedge clk_100) begin
    if (chk_en) begin
      exp_v = {m_step, m_lt, m_st, m_et, m_restart, m_act, ~m_act};
      got_v = {step, len_tick, sweep_tick, env_tick, ch_restart, ch_active, ch_reset};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL model_cycle t=%0t got={step,lt,st,et,rst,act,res}=%h exp=%h",
                 $time, got_v, exp_v);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_100);
    #2;
  endtask

  task automatic wait_len_tick(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (len_tick) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  int n_len, n_sw, n_env, seen;
  bit ok;

  initial begin
    reset = 1'b1; master_en = 1'b1; dac3_en = 1'b1;
    trig = '0; len_load = '0; len_en = '0;
    len1 = '0; len2 = '0; len3 = '0; len4 = '0;
    repeat (3) cyc();
    chk("reset_step", step, 0);
    chk("reset_active", ch_active, 4'h0);
    chk("reset_ch_reset", ch_reset, 4'hF);
    chk("reset_restart", ch_restart, 4'h0);
    chk("reset_ticks", {len_tick, sweep_tick, env_tick}, 0);
    reset = 1'b0;

    // Free-running frame sequence: 64 cycles = 16 steps.
    n_len = 0; n_sw = 0; n_env = 0;
    for (int i = 1; i <= 64; i++) begin
      cyc();
      if (len_tick)   n_len++;
      if (sweep_tick) n_sw++;
      if (env_tick)   n_env++;
      if (i == 3)  chk("step_before_first", step, 0);
      if (i == 4)  chk("first_step", step, 1);
      if (i == 28) chk("step_7", step, 7);
      if (i == 32) chk("step_wrap", step, 0);
    end
    chk("len_tick_count", n_len, 8);
    chk("sweep_tick_count", n_sw, 4);
    chk("env_tick_count", n_env, 2);

    // Channel 1: length 62 -> counter 2, expires on 2nd len_tick.
    len_en = 4'b0001; len1 = 6'd62;
    len_load = 4'b0001; cyc(); len_load = '0;
    chk("ch1_idle_after_load", ch_active[0], 0);
    trig = 4'b0001; cyc(); trig = '0;
    chk("ch1_active", ch_active[0], 1);
    chk("ch1_reset_low", ch_reset[0], 0);
    chk("ch1_restart_not_yet", ch_restart[0], 0);
    cyc();
    chk("ch1_restart", ch_restart[0], 1);
    cyc();
    chk("ch1_restart_end", ch_restart[0], 0);
    seen = 0;
    for (int i = 0; i < 40 && seen < 2; i++) begin
      cyc();
      if (len_tick) begin
        seen++;
        if (seen == 1) chk("ch1_after_tick1", ch_active[0], 1);
      end
    end
    chk("ch1_ticks_seen", seen, 2);
    chk("ch1_after_tick2", ch_active[0], LEN_ON ? 0 : 1);
    chk("ch1_reset_after_tick2", ch_reset[0], LEN_ON ? 1 : 0);

    // Channel 3: counter 0 reloads to 256 on trig.
    len_en = 4'b0101;
    wait_len_tick(20, ok);
    chk("align_ch3", ok, 1);
    trig = 4'b0100; cyc(); trig = '0;
    chk("ch3_active", ch_active[2], 1);
    cyc();
    chk("ch3_restart", ch_restart[2], 1);
    seen = 0;
    for (int i = 0; i < 2200 && seen < 256; i++) begin
      cyc();
      if (len_tick) begin
        seen++;
        if (seen == 255) chk("ch3_after_255", ch_active[2], 1);
      end
    end
    chk("ch3_ticks_seen", seen, 256);
    chk("ch3_after_256", ch_active[2], LEN_ON ? 0 : 1);

    // Channel 3 with DAC off: no activation, no restart.
    dac3_en = 1'b0;
    trig = 4'b0100; cyc(); trig = '0;
    chk("ch3_dac_off_active", ch_active[2], 0);
    cyc();
    chk("ch3_dac_off_restart1", ch_restart[2], 0);
    cyc();
    chk("ch3_dac_off_restart2", ch_restart[2], 0);
    // DAC dropping while active clears the channel on the next edge.
    dac3_en = 1'b1;
    trig = 4'b0100; cyc(); trig = '0;
    chk("ch3_reactivate", ch_active[2], 1);
    dac3_en = 1'b0; cyc();
    chk("ch3_dac_drop", ch_active[2], 0);
    dac3_en = 1'b1; cyc(); cyc();

    // Channel 2: counter 1, trig coincident with len_tick -> survives one tick.
    len_en = 4'b0111; len2 = 6'd63;
    wait_len_tick(20, ok);
    chk("align_ch2", ok, 1);
    len_load = 4'b0010; cyc(); len_load = '0;
    repeat (6) cyc();
    trig = 4'b0010; cyc(); trig = '0;
    chk("ch2_coincident_tick", len_tick, 1);
    chk("ch2_active", ch_active[1], 1);
    repeat (7) cyc();
    chk("ch2_before_next_tick", ch_active[1], 1);
    cyc();
    chk("ch2_next_tick", len_tick, 1);
    chk("ch2_expired", ch_active[1], LEN_ON ? 0 : 1);

    // Master disable mid-frame with all channels active.
    trig = 4'hF; cyc(); trig = '0;
    chk("all_active", ch_active, 4'hF);
    repeat (3) cyc();
    master_en = 1'b0; cyc();
    chk("dis_step", step, 0);
    chk("dis_active", ch_active, 4'h0);
    chk("dis_ch_reset", ch_reset, 4'hF);
    chk("dis_ticks", {len_tick, sweep_tick, env_tick}, 0);
    trig = 4'hF; len_load = 4'hF; cyc(); trig = '0; len_load = '0;
    chk("dis_trig_ignored", ch_active, 4'h0);
    cyc();
    chk("dis_no_restart", ch_restart, 4'h0);
    master_en = 1'b1;
    repeat (3) cyc();
    chk("reenable_step0", step, 0);
    cyc();
    chk("reenable_step1", step, 1);

    // Reset the cycle after a trig cancels the pending restart.
    trig = 4'b0001; cyc(); trig = '0;
    chk("pre_reset_active", ch_active[0], 1);
    reset = 1'b1; cyc();
    chk("mid_reset_restart", ch_restart, 4'h0);
    chk("mid_reset_active", ch_active, 4'h0);
    chk("mid_reset_ch_reset", ch_reset, 4'hF);
    chk("mid_reset_step", step, 0);
    reset = 1'b0; cyc();
    chk("post_reset_restart1", ch_restart, 4'h0);
    cyc();
    chk("post_reset_restart2", ch_restart, 4'h0);

    repeat (4) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
